adc_controller: RTL and testbench

Front-end controller for the scope's analog capture path: programs the two-channel programmable preamp over SPI once after reset, then runs back-to-back conversions on the dual 14-bit ADC sharing the same SPI clock. It publishes each completed sample pair on `adcReg` and a coarse channel-A level on `ledy`. It sits between the board pins and the sample buffer and trigger logic.

---
 rtl/adc_controller_pkg.sv | 27 ++
 rtl/adc_controller_if.sv | 22 ++
 rtl/adc_controller_spi_tick_gen.sv | 25 ++
 rtl/adc_controller.sv | 155 +++++++++++++++
 tb/tb_adc_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/adc_controller_pkg.sv
// Shared types and constants for the ADC front-end controller: FSM states,
// ADC frame bit positions and the default preamp gain word.
package adc_pkg;

    typedef enum logic [2:0] {
        RESET,
        AMP_LOAD,
        AMP_END,
        CONV,
        READ,
        STORE
    } adc_state_e;

    // Rising-SCK edge numbers (1-based) framing the two channels in a READ frame
    localparam int unsigned CHA_FIRST  = 3;
    localparam int unsigned CHA_LAST   = 16;
    localparam int unsigned CHB_FIRST  = 19;
    localparam int unsigned CHB_LAST   = 32;
    localparam int unsigned READ_EDGES = 34;

    localparam logic [7:0] AMP_GAIN_DEFAULT = 8'h11;

    function automatic logic [15:0] sext16(input logic [13:0] v);
        return {{2{v[13]}}, v};
    endfunction

endpackage

// File: rtl/adc_controller_if.sv
// Board-side pin bundle of the ADC controller plus the published sample/level outputs.
interface adc_controller_if;
    logic        AMP_DOUT;
    logic        AD_DOUT;
    logic        SPI_MOSI;
    logic        AMP_CS;
    logic        SPI_SCK;
    logic        AD_CONV;
    logic        AMP_SHDN;
    logic [31:0] adcReg;
    logic [7:0]  ledy;

    modport master (
        input  AMP_DOUT, AD_DOUT,
        output SPI_MOSI, AMP_CS, SPI_SCK, AD_CONV, AMP_SHDN, adcReg, ledy
    );

    modport slave (
        output AMP_DOUT, AD_DOUT,
        input  SPI_MOSI, AMP_CS, SPI_SCK, AD_CONV, AMP_SHDN, adcReg, ledy
    );
endinterface

// File: rtl/adc_controller_spi_tick_gen.sv
// Free-running 0..HALF_DIV-1 counter; tick_o marks the last count of each
// SPI half-period and paces every SCK event in the controller.
module spi_tick_gen #(
    parameter int unsigned HALF_DIV = 3
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/adc_controller.sv
// Preamp programming + dual 14-bit ADC conversion loop over a shared SPI clock.
// Define ADC_CONTROLLER_LEDY_EN to publish chA[13:6] on ledy; otherwise ledy is 0.
module adc_controller
    import adc_pkg::*;
#(
    parameter int unsigned HALF_DIV = 3,
    parameter logic [7:0]  AMP_GAIN = AMP_GAIN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    adc_controller_if.master pins
);
    localparam logic [6:0] AMP_LAST_HALF  = 7'd16;
    localparam logic [6:0] READ_LAST_HALF = 7'(2 * READ_EDGES - 1);

    logic tick;

    spi_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    adc_state_e  state_q, state_d;
    logic [6:0]  half_q, half_d;
    logic        sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d;
    logic        conv_q, conv_d, shdn_q, shdn_d;
    logic [7:0]  ampSh_q, ampSh_d, echo_q, echo_d;
    logic [13:0] chA_q, chA_d, chB_q, chB_d;
    logic [31:0] adcReg_q, adcReg_d;
    logic [6:0]  edgeNum;

    // Even half-periods of READ are rising SCK edges; number them from 1
    assign edgeNum = {1'b0, half_q[6:1]} + 7'd1;

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        sck_d    = sck_q;
        cs_d     = cs_q;
        mosi_d   = mosi_q;
        conv_d   = conv_q;
        shdn_d   = shdn_q;
        ampSh_d  = ampSh_q;
        echo_d   = echo_q;
        chA_d    = chA_q;
        chB_d    = chB_q;
        adcReg_d = adcReg_q;
        case (state_q)
            RESET: begin
                shdn_d  = 1'b0;
                half_d  = '0;
                state_d = AMP_LOAD;
            end
            AMP_LOAD: if (tick) begin
                half_d = half_q + 7'd1;
                if (half_q == 7'd0) begin
                    cs_d    = 1'b0;
                    mosi_d  = AMP_GAIN[7];
                    ampSh_d = {AMP_GAIN[6:0], 1'b0};
                end else if (half_q[0]) begin
                    sck_d  = 1'b1;
                    echo_d = {echo_q[6:0], pins.AMP_DOUT};
                end else begin
                    sck_d   = 1'b0;
                    mosi_d  = ampSh_q[7];
                    ampSh_d = {ampSh_q[6:0], 1'b0};
                    if (half_q == AMP_LAST_HALF) state_d = AMP_END;
                end
            end
            AMP_END: if (tick) begin
                cs_d    = 1'b1;
                conv_d  = 1'b1;
                state_d = CONV;
            end
            CONV: if (tick) begin
                conv_d  = 1'b0;
                half_d  = '0;
                state_d = READ;
            end
            READ: if (tick) begin
                half_d = half_q + 7'd1;
                if (!half_q[0]) begin
                    sck_d = 1'b1;
                    if (edgeNum >= 7'(CHA_FIRST) && edgeNum <= 7'(CHA_LAST))
                        chA_d = {chA_q[12:0], pins.AD_DOUT};
                    else if (edgeNum >= 7'(CHB_FIRST) && edgeNum <= 7'(CHB_LAST))
                        chB_d = {chB_q[12:0], pins.AD_DOUT};
                end else begin
                    sck_d = 1'b0;
                    if (half_q == READ_LAST_HALF) state_d = STORE;
                end
            end
            STORE: begin
                // Shift registers are idle here, so re-writing every clock is harmless
                adcReg_d = {sext16(chA_q), sext16(chB_q)};
                if (tick) begin
                    conv_d  = 1'b1;
                    state_d = CONV;
                end
            end
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RESET;
            half_q   <= '0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            conv_q   <= 1'b0;
            shdn_q   <= 1'b1;
            ampSh_q  <= '0;
            echo_q   <= '0;
            chA_q    <= '0;
            chB_q    <= '0;
            adcReg_q <= '0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            sck_q    <= sck_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            conv_q   <= conv_d;
            shdn_q   <= shdn_d;
            ampSh_q  <= ampSh_d;
            echo_q   <= echo_d;
            chA_q    <= chA_d;
            chB_q    <= chB_d;
            adcReg_q <= adcReg_d;
        end
    end

    assign pins.SPI_MOSI = mosi_q;
    assign pins.AMP_CS   = cs_q;
    assign pins.SPI_SCK  = sck_q;
    assign pins.AD_CONV  = conv_q;
    assign pins.AMP_SHDN = shdn_q;
    assign pins.adcReg   = adcReg_q;

`ifdef ADC_CONTROLLER_LEDY_EN
    logic [7:0] ledy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  ledy_q <= '0;
        else if (state_q == STORE) ledy_q <= chA_q[13:6];
    end

    assign pins.ledy = ledy_q;
`else
    assign pins.ledy = 8'h00;
`endif
endmodule

// File: tb/tb_adc_controller.sv
// Directed bench for adc_controller: reset values, preamp load, frame cadence,
// table-driven sample vectors from a serial ADC model, and mid-frame reset.
module tb_adc_controller;

`ifdef ADC_CONTROLLER_LEDY_EN
    localparam bit LEDY_EN = 1'b1;
`else
    localparam bit LEDY_EN = 1'b0;
`endif

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [31:0] expAdc;
        logic [7:0]  expLedy;
    } vec_t;

    logic        clk;
    logic        rst;
    int          total;
    int          passed;
    int unsigned cyc;
    logic [13:0] curA, curB;
    int          edgeN;
    vec_t        vecs[6];

    adc_controller_if pins ();

    adc_controller #(.HALF_DIV(3), .AMP_GAIN(8'h11)) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Serial ADC model: edges outside the channel windows return 1
    function automatic logic bitFor(input int e, input logic [13:0] a, input logic [13:0] b);
        if (e >= 3 && e <= 16)  return a[16 - e];
        if (e >= 19 && e <= 32) return b[32 - e];
        return 1'b1;
    endfunction

    always @(posedge pins.AD_CONV) begin
        edgeN = 0;
        pins.AD_DOUT = bitFor(1, curA, curB);
    end
    always @(posedge pins.SPI_SCK) edgeN = edgeN + 1;
    always @(negedge pins.SPI_SCK) pins.AD_DOUT = bitFor(edgeN + 1, curA, curB);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkResetPins(input string tag);
        checkOutput({tag, " pins"}, 32'({pins.SPI_MOSI, pins.AMP_CS, pins.SPI_SCK, pins.AD_CONV, pins.AMP_SHDN}), 32'b01001);
        checkOutput({tag, " adcReg"}, pins.adcReg, 32'h0);
        checkOutput({tag, " ledy"}, 32'(pins.ledy), 32'h0);
    endtask

    task automatic waitConvRise(input string name);
        bit   ok;
        logic prev;
        ok   = 1'b0;
        prev = pins.AD_CONV;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (pins.AD_CONV && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pins.AD_CONV;
        end
        checkOutput({name, " conv-rise"}, 32'(ok), 32'd1);
    endtask

    task automatic measureAmpLoad(input string tag);
        bit         ok;
        int         lowCnt, rises;
        logic       prevSck;
        logic [7:0] mosiSh;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pins.AMP_CS) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({tag, " cs-fall"}, 32'(ok), 32'd1);
        lowCnt  = 0;
        rises   = 0;
        mosiSh  = '0;
        prevSck = pins.SPI_SCK;
        while (ok && !pins.AMP_CS && lowCnt < 500) begin
            lowCnt = lowCnt + 1;
            @(negedge clk);
            if (pins.SPI_SCK && !prevSck) begin
                rises  = rises + 1;
                mosiSh = {mosiSh[6:0], pins.SPI_MOSI};
            end
            prevSck = pins.SPI_SCK;
        end
        checkOutput({tag, " cs-low-clocks"}, 32'(lowCnt), 32'd51);
        checkOutput({tag, " sck-rises"}, 32'(rises), 32'd8);
        checkOutput({tag, " mosi-word"}, 32'(mosiSh), 32'h11);
    endtask

    task automatic applyStimulus(input int idx);
        curA = vecs[idx].a;
        curB = vecs[idx].b;
        waitConvRise($sformatf("vec%0d start", idx));
        waitConvRise($sformatf("vec%0d end", idx));
    endtask

    initial begin
        bit          sckHigh;
        int          w;
        int unsigned t0;
        total  = 0;
        passed = 0;
        cyc    = 0;
        edgeN  = 0;
        curA   = 14'h3FFF;
        curB   = 14'h3FFF;
        pins.AMP_DOUT = 1'b0;
        pins.AD_DOUT  = 1'b1;

        vecs[0] = '{a: 14'h3FFF, b: 14'h3FFF, expAdc: 32'hFFFF_FFFF, expLedy: 8'hFF};
        vecs[1] = '{a: 14'h1000, b: 14'h0FFF, expAdc: 32'h1000_0FFF, expLedy: 8'h40};
        vecs[2] = '{a: 14'h2000, b: 14'h0001, expAdc: 32'hE000_0001, expLedy: 8'h80};
        vecs[3] = '{a: 14'h0000, b: 14'h0000, expAdc: 32'h0000_0000, expLedy: 8'h00};
        vecs[4] = '{a: 14'h1555, b: 14'h2AAA, expAdc: 32'h1555_EAAA, expLedy: 8'h55};
        vecs[5] = '{a: 14'h0ABC, b: 14'h3543, expAdc: 32'h0ABC_F543, expLedy: 8'h2A};

        rst = 1'b0;
        #20;
        checkResetPins("reset");
        #130;
        rst = 1'b1;
        #1;
        checkOutput("shdn at release", 32'(pins.AMP_SHDN), 32'd1);
        @(negedge clk);
        checkOutput("shdn one clock later", 32'(pins.AMP_SHDN), 32'd0);

        measureAmpLoad("amp");

        waitConvRise("cadence first");
        t0      = cyc;
        w       = 0;
        sckHigh = 1'b0;
        while (pins.AD_CONV && w < 20) begin
            w = w + 1;
            if (pins.SPI_SCK) sckHigh = 1'b1;
            @(negedge clk);
        end
        checkOutput("conv width", 32'(w), 32'd3);
        checkOutput("sck low in conv", 32'(sckHigh), 32'd0);
        waitConvRise("cadence second");
        checkOutput("conv period", cyc - t0, 32'd210);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i);
            checkOutput($sformatf("vec%0d adcReg", i), pins.adcReg, vecs[i].expAdc);
            checkOutput($sformatf("vec%0d ledy", i), 32'(pins.ledy), 32'(LEDY_EN ? vecs[i].expLedy : 8'h00));
        end

        // Reset in the middle of READ discards the partial frame
        waitConvRise("pre-reset");
        repeat (40) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkResetPins("mid-read reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        measureAmpLoad("reload");

        applyStimulus(1);
        checkOutput("after reload adcReg", pins.adcReg, vecs[1].expAdc);
        checkOutput("after reload ledy", 32'(pins.ledy), 32'(LEDY_EN ? vecs[1].expLedy : 8'h00));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
